rank_match_scheduler: RTL and testbench



---
 rtl/card_pkg.sv | 20 ++
 rtl/rank_match_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_rank_match_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_pkg.sv
// card_pkg
//   Shared constants and types for the card-identification blocks.
//   NUM_RANKS           : rank templates per region (0 = A ... 12 = K)
//   RANK_IDX_W          : width of a rank / kernel index
//   SCORE_W             : width of an XOR-template mismatch score (28x40 bits)
//   rank_sched_state_t  : rank_match_scheduler FSM states
package card_pkg;

   localparam int NUM_RANKS  = 13;
   localparam int RANK_IDX_W = $clog2(NUM_RANKS);
   localparam int SCORE_W    = 11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      REPORT = 2'd3
   } rank_sched_state_t;

endpackage

// File: rtl/rank_match_scheduler.sv
// rank_match_scheduler
//   Walks the shared XOR template-scoring engine through every rank kernel
//   once a card's rank-corner mask region is captured, keeps the minimum
//   mismatch score and reports the best rank with a reject flag.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   region_ready    : pulse, mask region for the current card is complete
//   eng_start       : pulse, engine starts scoring eng_kernel_sel
//   eng_kernel_sel  : kernel index driven to the engine
//   eng_done        : pulse, eng_score valid
//   eng_score       : mismatch count for the current kernel
//   busy            : scheduler not idle
//   result_valid    : pulse, rank_id / best_score / reject hold a new result
//   rank_id         : argmin kernel index (lowest index wins ties)
//   best_score      : minimum score of the run
//   reject          : best_score above REJECT_THRESHOLD
//   overrun         : pulse, a region_ready was dropped because we were busy
//   timeout_err     : sticky engine-timeout flag, cleared by the next run
module rank_match_scheduler
   import card_pkg::*;
#(
   parameter int NUM_KERNELS      = NUM_RANKS,
   parameter int SCORE_WIDTH      = SCORE_W,
   parameter int REJECT_THRESHOLD = 400,
   parameter int TIMEOUT_CYCLES   = 4096,
   localparam int IDX_W           = $clog2(NUM_KERNELS),
   localparam int CNT_W           = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   region_ready,
   output logic                   eng_start,
   output logic [IDX_W-1:0]       eng_kernel_sel,
   input  logic                   eng_done,
   input  logic [SCORE_WIDTH-1:0] eng_score,
   output logic                   busy,
   output logic                   result_valid,
   output logic [IDX_W-1:0]       rank_id,
   output logic [SCORE_WIDTH-1:0] best_score,
   output logic                   reject,
   output logic                   overrun,
   output logic                   timeout_err
);

   rank_sched_state_t state_q, state_d;

   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SCORE_WIDTH-1:0] best_q, best_d;
   logic [IDX_W-1:0]       best_idx_q, best_idx_d;
   logic [IDX_W-1:0]       rank_id_q, rank_id_d;
   logic [SCORE_WIDTH-1:0] best_score_q, best_score_d;
   logic                   reject_q, reject_d;
   logic                   overrun_q, overrun_d;
   logic                   timeout_err_q, timeout_err_d;

   logic                   last_kernel;
   logic                   cnt_at_max;
   logic                   take_score;
   logic [SCORE_WIDTH-1:0] cand_best;
   logic [IDX_W-1:0]       cand_idx;
   logic                   cand_reject;

   assign last_kernel = (idx_q == IDX_W'(NUM_KERNELS - 1));
   assign cnt_at_max  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Kernel 0 seeds the tracker; afterwards only a strictly smaller score
   // replaces it, so equal scores keep the lower (earlier) kernel index.
   assign take_score  = (idx_q == '0) || (eng_score < best_q);
   assign cand_best   = take_score ? eng_score : best_q;
   assign cand_idx    = take_score ? idx_q     : best_idx_q;
   assign cand_reject = (cand_best > SCORE_WIDTH'(REJECT_THRESHOLD));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   // eng_done is checked before the timeout so a done in the final
   // permitted cycle still counts.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (region_ready) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT: begin
            if (eng_done)        state_d = last_kernel ? REPORT : ISSUE;
            else if (cnt_at_max) state_d = IDLE;
         end
         REPORT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      eng_start    = (state_q == ISSUE);
      busy         = (state_q != IDLE);
      result_valid = (state_q == REPORT);
   end

   // ---------------- datapath next state ----------------
   // The result registers are loaded on the final eng_done so they are
   // already valid during the REPORT cycle that raises result_valid.
   always_comb begin
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      best_d        = best_q;
      best_idx_d    = best_idx_q;
      rank_id_d     = rank_id_q;
      best_score_d  = best_score_q;
      reject_d      = reject_q;
      timeout_err_d = timeout_err_q;
      // Any region_ready seen outside IDLE (REPORT included) is dropped.
      overrun_d     = region_ready && (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (region_ready) begin
               idx_d         = '0;
               timeout_err_d = 1'b0;
            end
         end
         ISSUE: cnt_d = '0;
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (eng_done) begin
               best_d     = cand_best;
               best_idx_d = cand_idx;
               if (last_kernel) begin
                  rank_id_d    = cand_idx;
                  best_score_d = cand_best;
                  reject_d     = cand_reject;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (cnt_at_max) begin
               timeout_err_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q         <= '0;
         cnt_q         <= '0;
         best_q        <= '0;
         best_idx_q    <= '0;
         rank_id_q     <= '0;
         best_score_q  <= '0;
         reject_q      <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         best_q        <= best_d;
         best_idx_q    <= best_idx_d;
         rank_id_q     <= rank_id_d;
         best_score_q  <= best_score_d;
         reject_q      <= reject_d;
         overrun_q     <= overrun_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // idx only moves on the WAIT->ISSUE transition, so the select is
   // stable from eng_start until eng_done.
   assign eng_kernel_sel = idx_q;
   assign rank_id        = rank_id_q;
   assign best_score     = best_score_q;
   assign reject         = reject_q;
   assign overrun        = overrun_q;
   assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_rank_match_scheduler.sv
// tb_rank_match_scheduler
//   Self-checking bench: a latency-programmable engine model answers
//   eng_start with a per-kernel score table; expected rank / score / reject
//   and result timing are computed from the scoring rules directly.
module tb_rank_match_scheduler;

   localparam int NK  = 13;
   localparam int IW  = $clog2(NK);
   localparam int SW  = 11;
   localparam int THR = 400;
   localparam int TO  = 4096;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          region_ready;
   logic          eng_start;
   logic [IW-1:0] eng_kernel_sel;
   logic          eng_done;
   logic [SW-1:0] eng_score;
   logic          busy;
   logic          result_valid;
   logic [IW-1:0] rank_id;
   logic [SW-1:0] best_score;
   logic          reject;
   logic          overrun;
   logic          timeout_err;

   rank_match_scheduler #(
      .NUM_KERNELS(NK), .SCORE_WIDTH(SW), .REJECT_THRESHOLD(THR), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .region_ready(region_ready),
      .eng_start(eng_start), .eng_kernel_sel(eng_kernel_sel),
      .eng_done(eng_done), .eng_score(eng_score), .busy(busy),
      .result_valid(result_valid), .rank_id(rank_id), .best_score(best_score),
      .reject(reject), .overrun(overrun), .timeout_err(timeout_err)
   );

   initial forever #5 clk = ~clk;

   int cyc = 0;
   int errs = 0;
   int checks = 0;
   int scores[NK];
   int lat = 5;
   int hang_k = -1;
   int starts = 0;
   int sel_log[$];
   int start_cyc[$];
   int results = 0;
   int overruns = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Engine model: done arrives `lat` cycles after the start cycle.
   initial begin
      int cnt;
      bit pend;
      int ks;
      pend = 0; cnt = 0; ks = 0;
      eng_done = 1'b0; eng_score = '0;
      forever begin
         @(negedge clk);
         eng_done = 1'b0;
         if (!rst_n) pend = 0;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               pend = 0;
               if (ks != hang_k) begin
                  eng_done  = 1'b1;
                  eng_score = SW'(scores[ks]);
               end
            end
         end
         if (eng_start) begin
            pend = 1; cnt = lat; ks = int'(eng_kernel_sel);
            starts++;
            sel_log.push_back(ks);
            start_cyc.push_back(cyc);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (result_valid) results++;
      if (overrun) overruns++;
   end

   // Reference: first minimum in ascending kernel order.
   function automatic void ref_model(input int s[NK], output int idx, output int best,
                                     output int rej);
      idx = 0; best = s[0];
      for (int k = 1; k < NK; k++)
         if (s[k] < best) begin best = s[k]; idx = k; end
      rej = (best > THR) ? 1 : 0;
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns the cycle index in which region_ready was high.
   task automatic start_run(output int t);
      region_ready = 1'b1;
      t = cyc;
      @(negedge clk);
      region_ready = 1'b0;
   endtask

   task automatic wait_result(input int bound, output bit got, output int rc);
      got = 0; rc = -1;
      for (int i = 0; i < bound && !got; i++) begin
         if (result_valid) begin got = 1; rc = cyc; end
         else @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; region_ready = 1'b0;
      step(3);
      checks++;
      if ({busy, eng_start, eng_kernel_sel, result_valid, rank_id, best_score, reject,
           overrun, timeout_err} !== '0) begin
         errs++;
         $display("FAIL reset_outputs: busy=%b start=%b sel=%0d rv=%b rank=%0d best=%0d rej=%b ovr=%b to=%b want all 0",
                  busy, eng_start, eng_kernel_sel, result_valid, rank_id, best_score, reject,
                  overrun, timeout_err);
      end
      rst_n = 1'b1;
      step(2);
      checks++;
      if ({busy, eng_start, result_valid} !== 3'b000) begin
         errs++;
         $display("FAIL post_reset_idle: busy=%b start=%b rv=%b want 000", busy, eng_start, result_valid);
      end
   endtask

   // Directed run: checks latency, busy edges, kernel order and the result.
   task automatic directed_run(input int L, input int e_idx, input int e_best, input int e_rej);
      int t, rc, bs, bo;
      bit got;
      lat = L; hang_k = -1;
      bs = starts; bo = overruns;
      start_run(t);
      checks++;
      if (busy !== 1'b1 || eng_start !== 1'b1 || eng_kernel_sel !== '0) begin
         errs++;
         $display("FAIL first_issue: busy=%b start=%b sel=%0d want 1 1 0", busy, eng_start, eng_kernel_sel);
      end
      wait_result(20 * (L + 1) + 20, got, rc);
      checks++;
      if (!got || rc != t + NK * (L + 1) + 1) begin
         errs++;
         $display("FAIL result_latency: got=%0d cycle=%0d want cycle %0d", got, rc - t, NK * (L + 1) + 1);
      end
      checks++;
      if (int'(rank_id) != e_idx || int'(best_score) != e_best || int'(reject) != e_rej) begin
         errs++;
         $display("FAIL result_value: rank=%0d best=%0d rej=%b want %0d %0d %0d",
                  rank_id, best_score, reject, e_idx, e_best, e_rej);
      end
      step(1);
      checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin
         errs++;
         $display("FAIL report_end: busy=%b rv=%b want 0 0", busy, result_valid);
      end
      checks++;
      if (starts - bs != NK || overruns != bo) begin
         errs++;
         $display("FAIL start_count: starts=%0d overruns=%0d want %0d 0", starts - bs, overruns - bo, NK);
      end
      for (int k = 0; k < NK && bs + k < sel_log.size(); k++) begin
         if (sel_log[bs + k] != k) begin
            checks++; errs++;
            $display("FAIL kernel_order: slot %0d sel=%0d want %0d", k, sel_log[bs + k], k);
         end
      end
   endtask

   task automatic test_descending;
      for (int k = 0; k < NK; k++) scores[k] = (k < 7) ? 900 - 100 * k : 500 + 10 * k;
      scores[7] = 120;
      directed_run(5, 7, 120, 0);
   endtask

   task automatic test_tie;
      for (int k = 0; k < NK; k++) scores[k] = 700;
      scores[2] = 300; scores[9] = 300;
      directed_run(3, 2, 300, 0);
   endtask

   task automatic test_all_max;
      for (int k = 0; k < NK; k++) scores[k] = 1119;
      directed_run(2, 0, 1119, 1);
   endtask

   task automatic test_threshold;
      for (int k = 0; k < NK; k++) scores[k] = 1000;
      scores[12] = THR;
      directed_run(1, 12, THR, 0);
      scores[12] = THR + 1;
      directed_run(1, 12, THR + 1, 1);
   endtask

   task automatic test_timeout;
      int t, s, bs, br;
      for (int k = 0; k < NK; k++) scores[k] = 600 - 10 * k;
      lat = 3; hang_k = 4;
      bs = starts; br = results;
      start_run(t);
      for (int i = 0; i < 200 && starts - bs < 5; i++) @(negedge clk);
      s = (starts - bs >= 5) ? start_cyc[bs + 4] : cyc;
      for (int i = 0; i < TO + 50 && cyc < s + TO; i++) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || timeout_err !== 1'b0) begin
         errs++;
         $display("FAIL timeout_last_wait: busy=%b to=%b want 1 0", busy, timeout_err);
      end
      step(1);
      checks++;
      if (busy !== 1'b0 || timeout_err !== 1'b1) begin
         errs++;
         $display("FAIL timeout_fire: busy=%b to=%b want 0 1", busy, timeout_err);
      end
      step(3);
      checks++;
      if (results != br || starts - bs != 5 || timeout_err !== 1'b1) begin
         errs++;
         $display("FAIL timeout_quiet: results=%0d starts=%0d to=%b want 0 5 1",
                  results - br, starts - bs, timeout_err);
      end
      hang_k = -1;
      start_run(t);
      checks++;
      if (timeout_err !== 1'b0) begin
         errs++;
         $display("FAIL timeout_clear: to=%b want 0", timeout_err);
      end
      begin
         bit got; int rc;
         wait_result(400, got, rc);
         checks++;
         if (!got || rank_id !== IW'(12) || best_score !== SW'(480)) begin
            errs++;
            $display("FAIL timeout_recover: got=%0d rank=%0d best=%0d want 1 12 480", got, rank_id, best_score);
         end
      end
      step(1);
   endtask

   task automatic test_overrun;
      int t, bs, bo, rc;
      bit got;
      for (int k = 0; k < NK; k++) scores[k] = 200 + ((k * 7) % NK) * 30;
      lat = 4; hang_k = -1;
      bs = starts; bo = overruns;
      start_run(t);
      for (int i = 0; i < 100 && starts - bs < 3; i++) @(negedge clk);
      step(1);
      region_ready = 1'b1;
      step(1);
      region_ready = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
         errs++;
         $display("FAIL overrun_wait: ovr=%b want 1", overrun);
      end
      step(1);
      checks++;
      if (overrun !== 1'b0) begin
         errs++;
         $display("FAIL overrun_pulse: ovr=%b want 0", overrun);
      end
      wait_result(200, got, rc);
      checks++;
      if (!got || rc != t + NK * 5 + 1 || rank_id !== '0 || best_score !== SW'(200)) begin
         errs++;
         $display("FAIL overrun_run: got=%0d lat=%0d rank=%0d best=%0d want 1 %0d 0 200",
                  got, rc - t, rank_id, best_score, NK * 5 + 1);
      end
      // region_ready during REPORT is also dropped
      region_ready = 1'b1;
      step(1);
      region_ready = 1'b0;
      checks++;
      if (overrun !== 1'b1 || busy !== 1'b0) begin
         errs++;
         $display("FAIL overrun_report: ovr=%b busy=%b want 1 0", overrun, busy);
      end
      step(2);
      checks++;
      if (busy !== 1'b0 || starts - bs != NK || overruns - bo != 2) begin
         errs++;
         $display("FAIL overrun_count: busy=%b starts=%0d ovr=%0d want 0 %0d 2",
                  busy, starts - bs, overruns - bo, NK);
      end
   endtask

   task automatic test_reset_midrun;
      int t, bs, e_idx, e_best, e_rej;
      for (int k = 0; k < NK; k++) scores[k] = 900 - 50 * k;
      lat = 5; hang_k = -1;
      bs = starts;
      start_run(t);
      for (int i = 0; i < 200 && starts - bs < 7; i++) @(negedge clk);
      step(2);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, eng_start, eng_kernel_sel, result_valid, rank_id, best_score, reject,
           overrun, timeout_err} !== '0) begin
         errs++;
         $display("FAIL midrun_reset: busy=%b start=%b sel=%0d rv=%b rank=%0d best=%0d rej=%b want all 0",
                  busy, eng_start, eng_kernel_sel, result_valid, rank_id, best_score, reject);
      end
      step(3);
      rst_n = 1'b1;
      step(2);
      for (int k = 0; k < NK; k++) scores[k] = $urandom_range(0, 1119);
      ref_model(scores, e_idx, e_best, e_rej);
      directed_run(5, e_idx, e_best, e_rej);
   endtask

   task automatic test_random;
      int e_idx, e_best, e_rej, a, b;
      for (int n = 0; n < 8; n++) begin
         for (int k = 0; k < NK; k++) scores[k] = $urandom_range(0, 1119);
         if (n[0]) begin
            a = $urandom_range(0, NK - 1); b = $urandom_range(0, NK - 1);
            scores[a] = $urandom_range(0, 40); scores[b] = scores[a];
         end
         ref_model(scores, e_idx, e_best, e_rej);
         directed_run($urandom_range(1, 6), e_idx, e_best, e_rej);
      end
   endtask

   initial begin
      rst_n = 1'b0; region_ready = 1'b0;
      for (int k = 0; k < NK; k++) scores[k] = 0;
      @(negedge clk);
      test_reset;
      test_descending;
      test_tie;
      test_all_max;
      test_threshold;
      test_timeout;
      test_overrun;
      test_reset_midrun;
      test_random;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
